// File: rtl/hssi_csr_access_master_if.sv
// Command / response / AVMM bundle for the HSSI CSR access master.
// The master modport is the view of the access engine; slave is the
// view of whatever drives commands and models the AVMM fabric.
interface hssi_csr_access_master_if #(
    parameter int AVMM_DATA_W = 32,
    parameter int AVMM_ADDR_W = 16
);
    // command channel
    logic                   cmd_valid;
    logic                   cmd_ready;
    logic                   cmd_write;
    logic [3:0]             cmd_port;
    logic [AVMM_ADDR_W-1:0] cmd_addr;
    logic [AVMM_DATA_W-1:0] cmd_wdata;
    // response channel
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [AVMM_DATA_W-1:0] rsp_rdata;
    logic [1:0]             rsp_status;
    // AVMM master side
    logic [AVMM_ADDR_W-1:0] o_avmm_addr;
    logic                   o_avmm_read;
    logic                   o_avmm_write;
    logic [AVMM_DATA_W-1:0] o_avmm_writedata;
    logic [AVMM_DATA_W-1:0] i_avmm_readdata;
    logic                   i_avmm_waitrequest;
    logic [3:0]             o_csr_port_sel;
    // status
    logic [15:0]            timeout_cnt;

    modport master (
        input  cmd_valid, cmd_write, cmd_port, cmd_addr, cmd_wdata,
        input  rsp_ready, i_avmm_readdata, i_avmm_waitrequest,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_status,
        output o_avmm_addr, o_avmm_read, o_avmm_write, o_avmm_writedata,
        output o_csr_port_sel, timeout_cnt
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_port, cmd_addr, cmd_wdata,
        output rsp_ready, i_avmm_readdata, i_avmm_waitrequest,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_status,
        input  o_avmm_addr, o_avmm_read, o_avmm_write, o_avmm_writedata,
        input  o_csr_port_sel, timeout_cnt
    );
endinterface

// File: rtl/hssi_csr_access_master.sv
// Single-outstanding CSR access engine: takes one command, runs one AVMM
// read or write to the selected Ethernet port (with a waitrequest timeout),
// and returns one response before accepting the next command.
module hssi_csr_access_master #(
    parameter int NUM_ETH        = 1,
    parameter int AVMM_DATA_W    = 32,
    parameter int AVMM_ADDR_W    = 16,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                          clk,
    input  logic                          reset,
    hssi_csr_access_master_if.master      bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam logic [1:0]  ST_OK      = 2'b00;
    localparam logic [1:0]  ST_TIMEOUT = 2'b01;
    localparam logic [1:0]  ST_BADPORT = 2'b10;
    // Timeout fires in the ACCESS cycle whose waitrequest makes the wait
    // counter reach TIMEOUT_CYCLES, so read/write is high for exactly
    // TIMEOUT_CYCLES stalled cycles.
    localparam logic [15:0] WAIT_LAST  = 16'(TIMEOUT_CYCLES - 1);

    state_t                 state, state_nxt;
    logic                   is_write;
    logic [AVMM_ADDR_W-1:0] addr_q;
    logic [AVMM_DATA_W-1:0] wdata_q;
    logic [3:0]             port_sel_q;
    logic [AVMM_DATA_W-1:0] rdata_q;
    logic [1:0]             status_q;
    logic [15:0]            wait_cnt;
    logic [15:0]            tmo_cnt_q;

    logic accept, bad_port, done, tmo;

    assign accept   = (state == IDLE) && bus.cmd_valid;
    assign bad_port = {28'd0, bus.cmd_port} >= 32'(NUM_ETH);
    // Completion wins: a timeout is only possible while waitrequest is high.
    assign done     = (state == ACCESS) && !bus.i_avmm_waitrequest;
    assign tmo      = (state == ACCESS) && bus.i_avmm_waitrequest && (wait_cnt == WAIT_LAST);

    // State register; async reset drops any in-flight access at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.cmd_valid) state_nxt = bad_port ? RESP : ACCESS;
            ACCESS:  if (done || tmo)   state_nxt = RESP;
            RESP:    if (bus.rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Command capture, wait counting and response/status registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            is_write   <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            port_sel_q <= '0;
            rdata_q    <= '0;
            status_q   <= ST_OK;
            wait_cnt   <= '0;
            tmo_cnt_q  <= '0;
        end else begin
            if (accept) begin
                is_write <= bus.cmd_write;
                addr_q   <= bus.cmd_addr;
                wdata_q  <= bus.cmd_wdata;
                wait_cnt <= '0;
                if (bad_port) begin
                    // port select deliberately untouched to keep the
                    // downstream readdata mux stable
                    rdata_q  <= '0;
                    status_q <= ST_BADPORT;
                end else begin
                    port_sel_q <= bus.cmd_port;
                end
            end
            if (state == ACCESS && bus.i_avmm_waitrequest)
                wait_cnt <= wait_cnt + 16'd1;
            if (done) begin
                rdata_q  <= is_write ? '0 : bus.i_avmm_readdata;
                status_q <= ST_OK;
            end else if (tmo) begin
                rdata_q  <= '0;
                status_q <= ST_TIMEOUT;
                if (tmo_cnt_q != 16'hFFFF) tmo_cnt_q <= tmo_cnt_q + 16'd1;
            end
        end
    end

    assign bus.cmd_ready        = (state == IDLE);
    assign bus.rsp_valid        = (state == RESP);
    assign bus.rsp_rdata        = rdata_q;
    assign bus.rsp_status       = status_q;
    assign bus.o_avmm_read      = (state == ACCESS) && !is_write;
    assign bus.o_avmm_write     = (state == ACCESS) &&  is_write;
    assign bus.o_avmm_addr      = addr_q;
    assign bus.o_avmm_writedata = wdata_q;
    assign bus.o_csr_port_sel   = port_sel_q;
    assign bus.timeout_cnt      = tmo_cnt_q;
endmodule

// File: doc/hssi_csr_access_master.md
HSSI_CSR_ACCESS_MASTER -- requirements
Module: hssi_csr_access_master

Interface
REQ-001 SHALL have parameter NUM_ETH, default 1: number of Ethernet ports behind the CSR fan-out.
REQ-002 SHALL have parameter AVMM_DATA_W, default 32: AVMM data width.
REQ-003 SHALL have parameter AVMM_ADDR_W, default 16: AVMM address width.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 256: maximum number of waitrequest-high cycles before an access is abandoned; legal range is 2..65535.
REQ-005 SHALL use one clock and one reset: clk  in  1  sole clock; reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have command ports: cmd_valid  in  1  command offered; cmd_ready  out  1  command accepted when high with cmd_valid.
REQ-007 SHALL have command payload ports: cmd_write  in  1  (1 = write, 0 = read); cmd_port  in  4  target port; cmd_addr  in  AVMM_ADDR_W  register address; cmd_wdata  in  AVMM_DATA_W  write data.
REQ-008 SHALL have response ports: rsp_valid  out  1; rsp_ready  in  1; rsp_rdata  out  AVMM_DATA_W; rsp_status  out  2  (00 OK, 01 TIMEOUT, 10 BAD_PORT).
REQ-009 SHALL have AVMM master ports: o_avmm_addr  out  AVMM_ADDR_W; o_avmm_read  out  1; o_avmm_write  out  1; o_avmm_writedata  out  AVMM_DATA_W.
REQ-010 SHALL have AVMM return ports and port select: i_avmm_readdata  in  AVMM_DATA_W; i_avmm_waitrequest  in  1; o_csr_port_sel  out  4  lane select.
REQ-011 SHALL have a status port: timeout_cnt  out  16  saturating count of timed-out accesses.

Function
REQ-012 SHALL implement the FSM states IDLE, ACCESS and RESP; cmd_ready SHALL be 1 only in IDLE, so at most one transaction is outstanding.
REQ-013 In IDLE, when cmd_valid is high, the block SHALL latch cmd_write, cmd_port, cmd_addr and cmd_wdata.
REQ-014 On an accepted command with cmd_port >= NUM_ETH, the block SHALL go to RESP with status 10 and rsp_rdata 0, issue no AVMM access, and leave o_csr_port_sel unchanged.
REQ-015 On an accepted command with a legal port, the block SHALL go to ACCESS; from the next cycle it SHALL drive o_csr_port_sel, o_avmm_addr and o_avmm_writedata from registers, with exactly one of o_avmm_read/o_avmm_write high.
REQ-016 In ACCESS, address, data, port select and read/write SHALL be held stable until completion or timeout.
REQ-017 A transfer SHALL complete in the first ACCESS cycle in which i_avmm_waitrequest = 0; the AVMM slave has zero read latency.
REQ-018 On a completed read, rsp_rdata SHALL capture i_avmm_readdata in that same cycle; on a completed write, rsp_rdata SHALL be 0; status SHALL be 00.
REQ-019 o_avmm_read and o_avmm_write SHALL deassert in the cycle after completion, and the FSM SHALL move to RESP.
REQ-020 A 16-bit wait counter SHALL clear on entry to ACCESS and increment on every ACCESS cycle with waitrequest high.
REQ-021 When the wait counter reaches TIMEOUT_CYCLES, the block SHALL drop read/write next cycle, go to RESP with status 01 and rsp_rdata 0, and increment timeout_cnt, saturating at 0xFFFF.
REQ-022 If completion and the timeout threshold occur in the same cycle, completion SHALL win.
REQ-023 In RESP, rsp_valid SHALL be 1, with rsp_rdata and rsp_status held stable, until rsp_ready is high; the FSM SHALL then return to IDLE in the next cycle.
REQ-024 Best-case latency SHALL be: command accepted at cycle N, read/write asserted at N+1, waitrequest low at N+1, rsp_valid at N+2.
REQ-025 o_csr_port_sel SHALL retain its last value outside ACCESS, so that the downstream readdata mux stays stable.

Reset
REQ-026 Asserting reset SHALL asynchronously force IDLE, with cmd_ready=1 once reset is released, and with rsp_valid, o_avmm_read and o_avmm_write at 0.
REQ-027 Asserting reset SHALL also clear rsp_rdata, rsp_status, o_avmm_addr, o_avmm_writedata, o_csr_port_sel, the wait counter and timeout_cnt to 0.
REQ-028 Reset asserted mid-ACCESS SHALL drop read/write immediately and SHALL generate no response.

Verification
REQ-029 Read of port 0, addr 0x0010, waitrequest low on first cycle, readdata 0xDEADBEEF -> o_avmm_read high for exactly 1 cycle, rsp_valid 2 cycles after accept, rdata 0xDEADBEEF, status 00.
REQ-030 Write of port 1 (NUM_ETH=2), addr 0x0004, wdata 0x12345678, waitrequest high 3 cycles -> write held 4 cycles with stable addr/data/port_sel=1, then status 00, rdata 0.
REQ-031 cmd_port=5 with NUM_ETH=4 -> no read/write pulse, rsp status 10, o_csr_port_sel unchanged.
REQ-032 TIMEOUT_CYCLES=8, waitrequest stuck high -> read dropped after 8 wait cycles, status 01, timeout_cnt increments 0 -> 1.
REQ-033 rsp_ready held low for 5 cycles -> rsp_valid/rdata/status stable and cmd_ready 0 throughout; second command accepted only after the response handshake.
REQ-034 Reset asserted during ACCESS with waitrequest high -> o_avmm_read 0 in the same cycle, no rsp_valid, cmd_ready 1 after release.
